// File: rtl/uart_bus_sched.sv
// uart_bus_sched: register-port master for the UART core. It runs the init
// writes, then polls status and round-robins the port between TX and RX.
//
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   stb_o/adr_o/we_o    registered UART bus access, one strobe per access
//   byte_sel_o/wdata_o  byte lanes and write data (zero on idle cycles)
//   rdata_i             UART read data, valid the cycle after a read strobe
//   tx_valid_i/tx_data_i/tx_ready_o   TX byte stream in
//   rx_valid_o/rx_data_o/rx_ready_i   RX byte stream out (one-entry register)
//   cfg_done_o          init writes complete
//   frame_err_o         sticky frame-error flag from status bit 4
module uart_bus_sched #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [15:0] BAUD_DIV   = 16'd868
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  stb_o,
    output logic [1:0]            adr_o,
    output logic                  we_o,
    output logic [3:0]            byte_sel_o,
    output logic [31:0]           wdata_o,
    input  logic [31:0]           rdata_i,
    input  logic                  tx_valid_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_ready_o,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    input  logic                  rx_ready_i,
    output logic                  cfg_done_o,
    output logic                  frame_err_o
);

    localparam logic [1:0] ADR_BAUD = 2'd0;
    localparam logic [1:0] ADR_CTRL = 2'd1;
    localparam logic [1:0] ADR_STAT = 2'd2;
    localparam logic [1:0] ADR_DATA = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_FRAME    = 4;

    typedef enum logic [2:0] {
        INIT_BAUD,
        INIT_CTRL,
        POLL,
        POLL_WAIT,
        TX_WR,
        RX_RD,
        RX_WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    // run is low only for the first edge after reset so that the
    // INIT_BAUD access is issued in the first cycle after release.
    logic run;

    logic last_tx;
    logic last_tx_nxt;
    logic [4:0] stat_q;
    logic [4:0] status;
    logic tx_elig;
    logic rx_elig;

    logic        stb_d;
    logic [1:0]  adr_d;
    logic        we_d;
    logic [3:0]  bsel_d;
    logic [31:0] wdata_d;

    logic unused_rdata;
    assign unused_rdata = ^rdata_i[31:DATA_WIDTH];

    // Next state and round-robin grant.
    always_comb begin
        state_nxt   = state;
        last_tx_nxt = last_tx;
        status      = stat_q;
        tx_elig     = 1'b0;
        rx_elig     = 1'b0;
        if (run) begin
            unique case (state)
                INIT_BAUD: state_nxt = INIT_CTRL;
                INIT_CTRL: state_nxt = POLL;
                POLL:      state_nxt = POLL_WAIT;
                POLL_WAIT: begin
                    status  = rdata_i[4:0];
                    tx_elig = tx_valid_i & ~status[ST_TX_FULL];
                    rx_elig = ~status[ST_RX_EMPTY] & ~rx_valid_o;
                    if (tx_elig && rx_elig) begin
                        if (last_tx) begin
                            state_nxt   = RX_RD;
                            last_tx_nxt = 1'b0;
                        end else begin
                            state_nxt   = TX_WR;
                            last_tx_nxt = 1'b1;
                        end
                    end else if (tx_elig) begin
                        state_nxt   = TX_WR;
                        last_tx_nxt = 1'b1;
                    end else if (rx_elig) begin
                        state_nxt   = RX_RD;
                        last_tx_nxt = 1'b0;
                    end else begin
                        state_nxt = POLL;
                    end
                end
                TX_WR:   state_nxt = POLL;
                RX_RD:   state_nxt = RX_WAIT;
                RX_WAIT: state_nxt = POLL;
                default: state_nxt = INIT_BAUD;
            endcase
        end
    end

    // Bus access for the state being entered; registered below so it
    // appears during that state's cycle.
    always_comb begin
        stb_d   = 1'b0;
        adr_d   = 2'd0;
        we_d    = 1'b0;
        bsel_d  = 4'd0;
        wdata_d = 32'd0;
        unique case (state_nxt)
            INIT_BAUD: begin
                stb_d   = 1'b1;
                adr_d   = ADR_BAUD;
                we_d    = 1'b1;
                bsel_d  = 4'b0011;
                wdata_d = {16'd0, BAUD_DIV};
            end
            INIT_CTRL: begin
                stb_d   = 1'b1;
                adr_d   = ADR_CTRL;
                we_d    = 1'b1;
                bsel_d  = 4'b0001;
                wdata_d = 32'h3;
            end
            POLL: begin
                stb_d = 1'b1;
                adr_d = ADR_STAT;
            end
            TX_WR: begin
                stb_d   = 1'b1;
                adr_d   = ADR_DATA;
                we_d    = 1'b1;
                bsel_d  = 4'b0001;
                wdata_d = {{(32-DATA_WIDTH){1'b0}}, tx_data_i};
            end
            RX_RD: begin
                stb_d = 1'b1;
                adr_d = ADR_DATA;
            end
            default: ;
        endcase
    end

    assign tx_ready_o = (state == TX_WR) & tx_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= INIT_BAUD;
            run     <= 1'b0;
            last_tx <= 1'b0;
            stat_q  <= 5'b01010;
        end else begin
            state   <= state_nxt;
            run     <= 1'b1;
            last_tx <= last_tx_nxt;
            stat_q  <= status;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stb_o      <= 1'b0;
            adr_o      <= 2'd0;
            we_o       <= 1'b0;
            byte_sel_o <= 4'd0;
            wdata_o    <= 32'd0;
        end else begin
            stb_o      <= stb_d;
            adr_o      <= adr_d;
            we_o       <= we_d;
            byte_sel_o <= bsel_d;
            wdata_o    <= wdata_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_done_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (run && state == INIT_CTRL) begin
                cfg_done_o <= 1'b1;
            end
            if (run && state == POLL_WAIT && rdata_i[ST_FRAME]) begin
                frame_err_o <= 1'b1;
            end
        end
    end

    // One-entry RX holding register; a load only happens while empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
        end else if (state == RX_WAIT) begin
            rx_valid_o <= 1'b1;
            rx_data_o  <= rdata_i[DATA_WIDTH-1:0];
        end else if (rx_valid_o && rx_ready_i) begin
            rx_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_bus_sched.sv
// tb_uart_bus_sched: randomized bench for uart_bus_sched with an
// expected-access queue model acting as the UART and stream endpoints.
module tb_uart_bus_sched;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        stb_o;
    logic [1:0]  adr_o;
    logic        we_o;
    logic [3:0]  byte_sel_o;
    logic [31:0] wdata_o;
    logic [31:0] rdata_i;
    logic        tx_valid_i;
    logic [7:0]  tx_data_i;
    logic        tx_ready_o;
    logic        rx_valid_o;
    logic [7:0]  rx_data_o;
    logic        rx_ready_i;
    logic        cfg_done_o;
    logic        frame_err_o;

    always #5 clk = ~clk;

    uart_bus_sched #(
        .DATA_WIDTH(8),
        .BAUD_DIV  (16'd868)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .stb_o      (stb_o),
        .adr_o      (adr_o),
        .we_o       (we_o),
        .byte_sel_o (byte_sel_o),
        .wdata_o    (wdata_o),
        .rdata_i    (rdata_i),
        .tx_valid_i (tx_valid_i),
        .tx_data_i  (tx_data_i),
        .tx_ready_o (tx_ready_o),
        .rx_valid_o (rx_valid_o),
        .rx_data_o  (rx_data_o),
        .rx_ready_i (rx_ready_i),
        .cfg_done_o (cfg_done_o),
        .frame_err_o(frame_err_o)
    );

    typedef struct {
        logic [39:0] bus;
        bit decide;
        bit load_rx;
        bit tx_wr;
        bit poll;
        bit rx_rd;
        bit set_cfg;
    } ev_t;

    ev_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    int tx_pct, full_pct, empty_pct, ferr_pct, rxrdy_pct;

    bit m_rx_valid, m_cfg, m_frame, m_last_tx;
    logic [7:0] m_rx_data;
    bit tx_retire, prev_poll, prev_rxrd, last_rxrd;
    bit alt_track, have_prev, prev_gtx;
    int nonalt, n_tx, n_rx;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] acc(input logic stb, input logic [1:0] adr,
                                        input logic we, input logic [3:0] bs,
                                        input logic [31:0] wd);
        return {stb, adr, we, bs, wd};
    endfunction

    function automatic ev_t mk_ev(input logic [39:0] bus);
        ev_t e;
        e.bus     = bus;
        e.decide  = 1'b0;
        e.load_rx = 1'b0;
        e.tx_wr   = 1'b0;
        e.poll    = 1'b0;
        e.rx_rd   = 1'b0;
        e.set_cfg = 1'b0;
        return e;
    endfunction

    task automatic push_init();
        ev_t e;
        e = mk_ev(acc(1'b1, 2'd0, 1'b1, 4'b0011, 32'h0000_0364));
        exp_q.push_back(e);
        e = mk_ev(acc(1'b1, 2'd1, 1'b1, 4'b0001, 32'h3));
        e.set_cfg = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic step();
        ev_t e;
        logic [31:0] r;
        logic [4:0] st;
        logic [4:0] s;
        bit te, re, gtx;
        @(posedge clk);
        #1;
        if (tx_retire) begin
            tx_valid_i = 1'b0;
            tx_retire  = 1'b0;
        end
        if (!tx_valid_i && ($urandom_range(99) < tx_pct)) begin
            tx_valid_i = 1'b1;
            tx_data_i  = 8'($urandom);
        end
        rx_ready_i = ($urandom_range(99) < rxrdy_pct);
        r = $urandom;
        if (prev_poll) begin
            st[0] = ($urandom_range(99) < full_pct);
            st[1] = r[1];
            st[2] = r[2];
            st[3] = ($urandom_range(99) < empty_pct);
            st[4] = ($urandom_range(99) < ferr_pct);
            rdata_i = {r[31:5], st};
        end else if (prev_rxrd) begin
            rdata_i = {r[31:8], 8'($urandom)};
        end else begin
            rdata_i = r;
        end

        @(negedge clk);
        if (exp_q.size() == 0) begin
            e = mk_ev(acc(1'b1, 2'd2, 1'b0, 4'd0, 32'd0));
            e.poll = 1'b1;
            exp_q.push_back(e);
            e = mk_ev(40'd0);
            e.decide = 1'b1;
            exp_q.push_back(e);
        end
        e = exp_q.pop_front();
        check("bus", 64'({stb_o, adr_o, we_o, byte_sel_o, wdata_o}), 64'(e.bus));
        check("tx_ready", 64'(tx_ready_o), 64'(e.tx_wr & tx_valid_i));
        check("rx_out", 64'({rx_valid_o, rx_data_o}), 64'({m_rx_valid, m_rx_data}));
        check("cfg_done", 64'(cfg_done_o), 64'(m_cfg));
        check("frame_err", 64'(frame_err_o), 64'(m_frame));

        if (e.decide) begin
            s = rdata_i[4:0];
            if (s[4]) m_frame = 1'b1;
            te = tx_valid_i && !s[0];
            re = !s[3] && !m_rx_valid;
            if (te || re) begin
                gtx = (te && re) ? !m_last_tx : te;
                if (alt_track && te && re && have_prev && gtx == prev_gtx)
                    nonalt++;
                prev_gtx  = gtx;
                have_prev = 1'b1;
                m_last_tx = gtx;
                if (gtx) begin
                    ev_t t;
                    t = mk_ev(acc(1'b1, 2'd3, 1'b1, 4'b0001, {24'd0, tx_data_i}));
                    t.tx_wr = 1'b1;
                    exp_q.push_back(t);
                    n_tx++;
                end else begin
                    ev_t t;
                    t = mk_ev(acc(1'b1, 2'd3, 1'b0, 4'd0, 32'd0));
                    t.rx_rd = 1'b1;
                    exp_q.push_back(t);
                    t = mk_ev(40'd0);
                    t.load_rx = 1'b1;
                    exp_q.push_back(t);
                    n_rx++;
                end
            end
        end
        prev_poll = e.poll;
        prev_rxrd = e.rx_rd;
        last_rxrd = e.rx_rd;
        if (e.set_cfg) m_cfg = 1'b1;
        if (e.tx_wr && tx_valid_i) tx_retire = 1'b1;
        if (m_rx_valid && rx_ready_i) m_rx_valid = 1'b0;
        if (e.load_rx) begin
            m_rx_valid = 1'b1;
            m_rx_data  = rdata_i[7:0];
        end
    endtask

    task automatic do_reset();
        rst_ni     = 1'b0;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'd0;
        tx_retire  = 1'b0;
        rx_ready_i = 1'b0;
        rdata_i    = 32'd0;
        prev_poll  = 1'b0;
        prev_rxrd  = 1'b0;
        last_rxrd  = 1'b0;
        exp_q.delete();
        m_rx_valid = 1'b0;
        m_rx_data  = 8'd0;
        m_cfg      = 1'b0;
        m_frame    = 1'b0;
        m_last_tx  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bus", 64'({stb_o, adr_o, we_o, byte_sel_o, wdata_o}), 64'd0);
        check("rst_misc", 64'({tx_ready_o, rx_valid_o, rx_data_o,
                               cfg_done_o, frame_err_o}), 64'd0);
        rst_ni = 1'b1;
        push_init();
    endtask

    task automatic set_mode(input int tp, input int fp, input int ep,
                            input int xp, input int rp);
        tx_pct    = tp;
        full_pct  = fp;
        empty_pct = ep;
        ferr_pct  = xp;
        rxrdy_pct = rp;
    endtask

    initial begin
        bit found;
        alt_track = 1'b0;
        have_prev = 1'b0;
        nonalt    = 0;
        n_tx      = 0;
        n_rx      = 0;
        set_mode(0, 0, 100, 0, 50);
        do_reset();

        // idle: init then polls only
        repeat (20) step();

        // mixed random traffic
        set_mode(40, 30, 50, 0, 60);
        repeat (400) step();

        // TX blocked by full FIFO, then released
        set_mode(100, 100, 100, 0, 50);
        repeat (20) step();
        set_mode(100, 0, 100, 0, 50);
        repeat (20) step();

        // RX held by a stalled consumer
        set_mode(0, 0, 0, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (rx_valid_o) found = 1'b1;
        end
        check("rx_loaded", 64'(found), 64'd1);
        repeat (20) step();
        check("rx_hold", 64'(rx_valid_o), 64'd1);
        set_mode(0, 0, 0, 0, 100);
        repeat (10) step();

        // both sides continuously eligible
        set_mode(100, 0, 0, 0, 100);
        n_tx = 0;
        n_rx = 0;
        nonalt = 0;
        alt_track = 1'b1;
        repeat (80) step();
        alt_track = 1'b0;
        check("alternate", 64'(nonalt), 64'd0);
        check("no_starve", 64'((n_tx > 4) && (n_rx > 4)), 64'd1);

        // frame error is sticky
        set_mode(0, 0, 100, 100, 100);
        repeat (6) step();
        set_mode(0, 0, 100, 0, 100);
        repeat (12) step();
        check("frame_sticky", 64'(frame_err_o), 64'd1);

        // reset asserted during RX_WAIT
        set_mode(0, 0, 0, 0, 100);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (last_rxrd) found = 1'b1;
        end
        check("rxrd_seen", 64'(found), 64'd1);
        if (found) begin
            @(posedge clk);
            #2;
            rst_ni = 1'b0;
            #1;
            check("async_bus", 64'({stb_o, adr_o, we_o, byte_sel_o, wdata_o}), 64'd0);
            check("async_misc", 64'({tx_ready_o, rx_valid_o, cfg_done_o,
                                     frame_err_o}), 64'd0);
        end
        do_reset();
        set_mode(40, 30, 50, 3, 60);
        repeat (150) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
